// File: rtl/membus_arbiter_pkg.sv
// Shared types, default address window and check helpers for the memory bus arbiter.
package membus_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;

   localparam logic [ADDR_W-1:0] DEF_MEM_BASE = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] DEF_MEM_END  = 32'h0000_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ERR   = 2'd3
   } MembusArbState;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } Owner;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              wen;
      logic [DATA_W-1:0] wdata;
      logic [MASK_W-1:0] wmask;
   } MemReq;

   // Inclusive window check: lo <= a <= hi.
   function automatic logic x_in_range(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] lo,
                                       input logic [ADDR_W-1:0] hi);
      return (a >= lo) && (a <= hi);
   endfunction

   function automatic logic ialigned(input logic [ADDR_W-1:0] a);
      return (a[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/membus_arb_grant.sv
// Grant selection between fetch (I) and load/store (D) ports.
// MEMBUS_ARB_ROUND_ROBIN_EN selects round-robin with a last_grant flop; otherwise fixed D>I.
module membus_arb_grant
   import membus_arbiter_pkg::*;
(
`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
   input  logic clk,
   input  logic reset,
   input  logic i_accept,
   input  Owner i_accept_owner,
`endif
   input  logic i_i_valid,
   input  logic i_d_valid,
   output logic o_grant_i,
   output logic o_grant_d
);

`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
   Owner r_last_grant;

   // Every accept counts, including ones that end in an error response.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= OWNER_D;
      end else if (i_accept) begin
         r_last_grant <= i_accept_owner;
      end
   end

   always_comb begin
      o_grant_i = 1'b0;
      o_grant_d = 1'b0;
      if (i_i_valid && i_d_valid) begin
         o_grant_i = (r_last_grant == OWNER_D);
         o_grant_d = (r_last_grant == OWNER_I);
      end else begin
         o_grant_i = i_i_valid;
         o_grant_d = i_d_valid;
      end
   end
`else
   assign o_grant_d = i_d_valid;
   assign o_grant_i = i_i_valid && !i_d_valid;
`endif

endmodule

// File: rtl/membus_arbiter.sv
// Single-outstanding arbiter sharing main memory between fetch and load/store ports,
// with range/alignment fault checks. Optional round-robin via MEMBUS_ARB_ROUND_ROBIN_EN.
module membus_arbiter
   import membus_arbiter_pkg::*;
#(
   parameter logic [31:0] MEM_BASE = DEF_MEM_BASE,
   parameter logic [31:0] MEM_END  = DEF_MEM_END
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        i_req_valid,
   output logic        i_req_ready,
   input  logic [31:0] i_req_addr,
   output logic        i_resp_valid,
   output logic [31:0] i_resp_rdata,
   output logic        i_resp_error,

   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic [31:0] d_req_addr,
   input  logic        d_req_wen,
   input  logic [31:0] d_req_wdata,
   input  logic [3:0]  d_req_wmask,
   output logic        d_resp_valid,
   output logic [31:0] d_resp_rdata,
   output logic        d_resp_error,

   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata
);

   MembusArbState r_state;
   Owner          r_owner;
   MemReq         r_req;

   logic  w_grant_i;
   logic  w_grant_d;
   logic  w_accept;
   Owner  w_owner;
   MemReq w_req;
   logic  w_err;
   logic  w_resp_fire;
   logic  w_resp_err;
   logic  w_resp_data_ok;
   logic [31:0] w_resp_rdata;

   membus_arb_grant u_grant (
`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
      .clk            (clk),
      .reset          (reset),
      .i_accept       (w_accept),
      .i_accept_owner (w_owner),
`endif
      .i_i_valid      (i_req_valid),
      .i_d_valid      (d_req_valid),
      .o_grant_i      (w_grant_i),
      .o_grant_d      (w_grant_d)
   );

   assign w_accept = (r_state == ST_IDLE) && (w_grant_i || w_grant_d);

   // Request as it would be latched; fetches are full-word reads.
   always_comb begin
      w_owner     = OWNER_D;
      w_req.addr  = d_req_addr;
      w_req.wen   = d_req_wen;
      w_req.wdata = d_req_wdata;
      w_req.wmask = d_req_wmask;
      if (w_grant_i) begin
         w_owner     = OWNER_I;
         w_req.addr  = i_req_addr;
         w_req.wen   = 1'b0;
         w_req.wdata = 32'h0;
         w_req.wmask = 4'hF;
      end
   end

   assign w_err = !x_in_range(w_req.addr, MEM_BASE, MEM_END) ||
                  (w_grant_i && !ialigned(w_req.addr));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_owner <= OWNER_D;
         r_req   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_owner <= w_owner;
                  r_req   <= w_req;
                  r_state <= w_err ? ST_ERR : ST_ISSUE;
               end
            end
            ST_ISSUE: if (mem_req_ready)  r_state <= ST_WAIT;
            ST_WAIT:  if (mem_resp_valid) r_state <= ST_IDLE;
            ST_ERR:   r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign i_req_ready = (r_state == ST_IDLE) && w_grant_i;
   assign d_req_ready = (r_state == ST_IDLE) && w_grant_d;

   // Memory data is forwarded only for a completing read; stores and faults return zero.
   assign w_resp_data_ok = (r_state == ST_WAIT) && mem_resp_valid;
   assign w_resp_err     = (r_state == ST_ERR);
   assign w_resp_fire    = w_resp_data_ok || w_resp_err;
   assign w_resp_rdata   = (w_resp_data_ok && !r_req.wen) ? mem_resp_rdata : 32'h0;

   assign i_resp_valid = w_resp_fire && (r_owner == OWNER_I);
   assign i_resp_error = w_resp_err  && (r_owner == OWNER_I);
   assign i_resp_rdata = (r_owner == OWNER_I) ? w_resp_rdata : 32'h0;

   assign d_resp_valid = w_resp_fire && (r_owner == OWNER_D);
   assign d_resp_error = w_resp_err  && (r_owner == OWNER_D);
   assign d_resp_rdata = (r_owner == OWNER_D) ? w_resp_rdata : 32'h0;

   assign mem_req_valid = (r_state == ST_ISSUE);
   assign mem_req_addr  = r_req.addr;
   assign mem_req_wen   = r_req.wen;
   assign mem_req_wdata = r_req.wdata;
   assign mem_req_wmask = r_req.wmask;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed self-checking bench for membus_arbiter (either arbitration build).
module tb_membus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req_valid;
   logic        i_req_ready;
   logic [31:0] i_req_addr;
   logic        i_resp_valid;
   logic [31:0] i_resp_rdata;
   logic        i_resp_error;
   logic        d_req_valid;
   logic        d_req_ready;
   logic [31:0] d_req_addr;
   logic        d_req_wen;
   logic [31:0] d_req_wdata;
   logic [3:0]  d_req_wmask;
   logic        d_resp_valid;
   logic [31:0] d_resp_rdata;
   logic        d_resp_error;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   membus_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .i_req_valid    (i_req_valid),
      .i_req_ready    (i_req_ready),
      .i_req_addr     (i_req_addr),
      .i_resp_valid   (i_resp_valid),
      .i_resp_rdata   (i_resp_rdata),
      .i_resp_error   (i_resp_error),
      .d_req_valid    (d_req_valid),
      .d_req_ready    (d_req_ready),
      .d_req_addr     (d_req_addr),
      .d_req_wen      (d_req_wen),
      .d_req_wdata    (d_req_wdata),
      .d_req_wmask    (d_req_wmask),
      .d_resp_valid   (d_resp_valid),
      .d_resp_rdata   (d_resp_rdata),
      .d_resp_error   (d_resp_error),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wen    (mem_req_wen),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_req_valid    = 1'b0;
      i_req_addr     = 32'h0;
      d_req_valid    = 1'b0;
      d_req_addr     = 32'h0;
      d_req_wen      = 1'b0;
      d_req_wdata    = 32'h0;
      d_req_wmask    = 4'h0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 32'h0;
   endtask

   // One transaction against an ideal memory (ready at N+1, response at N+2).
   task automatic run_xact(input bit is_d, input logic [31:0] addr, input bit wen,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input logic [31:0] mem_rd, input bit exp_err);
      logic [31:0] exp_rd;
      exp_rd = (wen || exp_err) ? 32'h0 : mem_rd;
      if (is_d) begin
         d_req_valid = 1'b1; d_req_addr = addr; d_req_wen = wen;
         d_req_wdata = wdata; d_req_wmask = wmask;
      end else begin
         i_req_valid = 1'b1; i_req_addr = addr;
      end
      #1;
      chk("acc_ready",       is_d ? d_req_ready : i_req_ready, 1);
      chk("acc_other_ready", is_d ? i_req_ready : d_req_ready, 0);
      tick();
      i_req_valid = 1'b0; d_req_valid = 1'b0; mem_req_ready = 1'b1;
      #1;
      if (exp_err) begin
         chk("err_valid", is_d ? d_resp_valid : i_resp_valid, 1);
         chk("err_flag",  is_d ? d_resp_error : i_resp_error, 1);
         chk("err_rdata", is_d ? d_resp_rdata : i_resp_rdata, 0);
         chk("err_other", is_d ? i_resp_valid : d_resp_valid, 0);
         chk("err_no_mem", mem_req_valid, 0);
         tick();
         mem_req_ready = 1'b0;
         #1;
         chk("err_pulse_end", is_d ? d_resp_valid : i_resp_valid, 0);
         chk("err_no_mem2", mem_req_valid, 0);
      end else begin
         chk("req_valid", mem_req_valid, 1);
         chk("req_addr",  mem_req_addr, addr);
         chk("req_wen",   mem_req_wen, is_d ? wen : 1'b0);
         chk("req_wdata", mem_req_wdata, is_d ? wdata : 32'h0);
         chk("req_wmask", mem_req_wmask, is_d ? wmask : 4'hF);
         chk("req_no_resp", is_d ? d_resp_valid : i_resp_valid, 0);
         tick();
         mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = mem_rd;
         #1;
         chk("resp_valid", is_d ? d_resp_valid : i_resp_valid, 1);
         chk("resp_rdata", is_d ? d_resp_rdata : i_resp_rdata, exp_rd);
         chk("resp_error", is_d ? d_resp_error : i_resp_error, 0);
         chk("resp_other", is_d ? i_resp_valid : d_resp_valid, 0);
         chk("resp_req_drop", mem_req_valid, 0);
         tick();
         mem_resp_valid = 1'b0;
         #1;
         chk("resp_pulse_end", is_d ? d_resp_valid : i_resp_valid, 0);
      end
   endtask

   initial begin
      bit rr;
      bit last_d;
      bit exp_d;
`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      chk("rst_mem_valid", mem_req_valid, 0);
      chk("rst_mem_addr",  mem_req_addr, 0);
      chk("rst_mem_wmask", mem_req_wmask, 0);
      chk("rst_i_resp",    i_resp_valid, 0);
      chk("rst_d_resp",    d_resp_valid, 0);
      chk("rst_i_ready",   i_req_ready, 0);
      chk("rst_d_ready",   d_req_ready, 0);
      reset = 1'b0;
      tick();

      // Fetch with ideal memory
      run_xact(1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

      // Store with memory holding ready low for 3 cycles
      d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_wen = 1'b1;
      d_req_wdata = 32'h1234_5678; d_req_wmask = 4'b0011;
      #1;
      chk("st_ready", d_req_ready, 1);
      tick();
      d_req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("st_hold_valid", mem_req_valid, 1);
         chk("st_hold_addr",  mem_req_addr, 32'h200);
         chk("st_hold_wdata", mem_req_wdata, 32'h1234_5678);
         chk("st_hold_wmask", mem_req_wmask, 4'b0011);
         chk("st_hold_wen",   mem_req_wen, 1);
         tick();
      end
      mem_req_ready = 1'b1;
      #1;
      chk("st_issue", mem_req_valid, 1);
      tick();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
      #1;
      chk("st_resp_valid", d_resp_valid, 1);
      chk("st_resp_rdata", d_resp_rdata, 0);
      chk("st_resp_error", d_resp_error, 0);
      chk("st_resp_i",     i_resp_valid, 0);
      tick();
      mem_resp_valid = 1'b0;
      #1;
      chk("st_pulse_end", d_resp_valid, 0);

      // Faults: misaligned fetch, out-of-range load
      run_xact(1'b0, 32'h0000_0102, 1'b0, 32'h0, 4'h0, 32'h5555_5555, 1'b1);
      run_xact(1'b1, 32'h0001_0000, 1'b0, 32'h0, 4'hF, 32'h5555_5555, 1'b1);
      last_d = 1'b1;

      // Both ports valid for four transactions
      d_req_valid = 1'b1; d_req_addr = 32'h300; d_req_wen = 1'b0; d_req_wmask = 4'hF;
      i_req_valid = 1'b1; i_req_addr = 32'h400;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0A0B_0C0D;
      for (int t = 0; t < 4; t++) begin
         #1;
         exp_d = rr ? !last_d : 1'b1;
         chk("arb_d_ready", d_req_ready, exp_d);
         chk("arb_i_ready", i_req_ready, !exp_d);
         last_d = exp_d;
         tick();
         tick();
         chk("arb_resp_owner", exp_d ? d_resp_valid : i_resp_valid, 1);
         chk("arb_resp_other", exp_d ? i_resp_valid : d_resp_valid, 0);
         tick();
      end
      clear_inputs();
      tick();

      // Reset while waiting for the memory response
      i_req_valid = 1'b1; i_req_addr = 32'h500;
      #1;
      chk("rw_ready", i_req_ready, 1);
      tick();
      i_req_valid = 1'b0; mem_req_ready = 1'b1;
      #1;
      chk("rw_issue", mem_req_valid, 1);
      tick();
      mem_req_ready = 1'b0;
      #1;
      chk("rw_wait", mem_req_valid, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_2222;
      #1;
      chk("rw_no_i_resp", i_resp_valid, 0);
      chk("rw_no_d_resp", d_resp_valid, 0);
      chk("rw_addr_clr",  mem_req_addr, 0);
      tick();
      mem_resp_valid = 1'b0;
      #1;
      chk("rw_stale_i", i_resp_valid, 0);
      chk("rw_stale_mem", mem_req_valid, 0);
      run_xact(1'b0, 32'h0000_0600, 1'b0, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0);

      // Window boundaries
      run_xact(1'b1, 32'h0000_FFFF, 1'b0, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0);
      run_xact(1'b1, 32'h0000_0000, 1'b0, 32'h0, 4'hF, 32'h7777_0001, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
